matrix_mem_arbiter: RTL and testbench
=====================================

Name: matrix_mem_arbiter

Overview:
- Shares the single-port 4x200-bit matrix memory between two requesters: the host bridge (loads instruction word and matrices, reads results) and the coprocessor control FSM (FETCH/WRITEBACK accesses).
- Performs round-robin arbitration with a control-unit lock that reserves the port for a whole operation.
- Tags and returns read data to the requester that issued the read.
- Sits between the bus bridge, the control unit and the memory macro.

Parameters:
DATA_W, 200, memory word width (one full 5x5 int8 matrix)
ADDR_W, 2, memory address width (word 0 instr, 1 matrix A, 2 matrix B, 3 result)
READ_LAT, 1, memory read latency in clk_button cycles (1..3)
WAIT_W, 8, width of the saturating host-wait counter

Ports:
clk_button  in  1  clock
rst  in  1  asynchronous, active-high reset
host_req  in  1  host access request; held with addr/we/wdata until accepted
host_we  in  1  1 = write, 0 = read
host_addr  in  ADDR_W  host address
host_wdata  in  DATA_W  host write data
host_gnt  out  1  combinational accept; transfer when host_req && host_gnt
host_rvalid  out  1  host read data valid, one cycle pulse
host_rdata  out  DATA_W  host read data
cu_req  in  1  control-unit request
cu_we  in  1  control-unit write enable
cu_addr  in  ADDR_W  control-unit address
cu_wdata  in  DATA_W  control-unit write data
cu_gnt  out  1  combinational accept for control unit
cu_rvalid  out  1  control-unit read data valid pulse
cu_rdata  out  DATA_W  control-unit read data
cu_lock  in  1  control unit reserves port (START..CLN of an operation)
locked  out  1  1 while arbiter is in LOCKED state
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_wren  out  1  memory write enable
mem_q  in  DATA_W  memory read data, valid READ_LAT cycles after address
host_wait_cnt  out  WAIT_W  saturating count of cycles host_req was refused

Behaviour:
- Reset (async, any state): state=OPEN, last_grant=HOST, return pipeline cleared, host_wait_cnt=0, locked=0. All rvalid=0 and rdata=0. gnt, mem_wren and mem_addr are 0 while no request. In-flight reads are dropped; no rvalid follows a reset.
- At most one access per cycle. mem_addr, mem_wdata and mem_wren are combinational from the winning requester. With no winner: mem_wren=0, mem_addr=0, mem_wdata=0.
- OPEN state:
  - Only one requester asserting: it wins.
  - Both asserting: the one not equal to last_grant wins.
  - last_grant updates on every accepted transfer.
- LOCKED state: only the CU can win; host_gnt=0.
- Transitions:
  - OPEN->LOCKED on a clock edge with cu_lock=1.
  - LOCKED->OPEN on an edge with cu_lock=0. last_grant is forced to CU on exit, so the host wins the first contention after unlock.
  - cu_lock rising in the same cycle as a host accept: the host transfer completes; the lock takes effect next cycle.
- Read return: each accepted read pushes {valid, owner} into a READ_LAT-deep shift register. When the entry exits, the owner's rvalid=1 for one cycle and its rdata=mem_q (registered hold until next return). Writes push valid=0.
- Back-to-back reads from alternating owners return in issue order, one per cycle.
- Write then read to the same address on consecutive cycles returns the new data (memory is write-first in cycle order, no bypass needed).
- host_wait_cnt increments on each cycle with host_req=1 and host_gnt=0, saturates at 2^WAIT_W-1, and clears only on reset.
- Protocol violations, such as changing addr/we/wdata while req=1 and gnt=0, are undefined. Verification may assert against them.

Decomposition:
- Shared package holds:
  - owner encoding: OWN_HOST=0, OWN_CU=1
  - state encoding: OPEN=0, LOCKED=1
  - memory map constants: ADDR_INSTR=0, ADDR_MAT_A=1, ADDR_MAT_B=2, ADDR_RESULT=3
- One sub-module, rd_return_pipe: the READ_LAT-deep valid/owner shift register with a demux of mem_q to the two rdata/rvalid outputs.

Test Plan:
- Reset then host write addr1=200'h01_02..19, host read addr1 -> host_gnt same cycle as req; host_rvalid READ_LAT cycles later with rdata equal to the written word; cu_rvalid stays 0.
- host_req and cu_req held together for 4 cycles, last_grant=HOST after reset -> grants alternate CU, HOST, CU, HOST; host_wait_cnt=2.
- cu_lock=1 for 10 cycles with host_req held -> locked=1 from the next cycle, host_gnt=0 throughout, host_wait_cnt counts 10. After cu_lock=0 and both requesting, the host wins first.
- CU reads addr0 then host reads addr3 on consecutive cycles, READ_LAT=2 -> cu_rvalid then host_rvalid on consecutive cycles, each with the data of its own address.
- Assert rst while a read is in flight -> no rvalid afterwards; all outputs 0; locked=0.
- host_req held 300 cycles while locked, WAIT_W=8 -> host_wait_cnt saturates at 255.

Source files
------------

// File: rtl/matrix_mem_arbiter_pkg.sv
// Shared encodings for the matrix memory arbiter: requester owners, arbiter states,
// the matrix memory map and the tag carried down the read-return pipe.
package matrix_mem_arbiter_pkg;

  localparam logic OWN_HOST = 1'b0;
  localparam logic OWN_CU   = 1'b1;

  localparam logic ST_OPEN   = 1'b0;
  localparam logic ST_LOCKED = 1'b1;

  localparam logic [1:0] ADDR_INSTR  = 2'd0;
  localparam logic [1:0] ADDR_MAT_A  = 2'd1;
  localparam logic [1:0] ADDR_MAT_B  = 2'd2;
  localparam logic [1:0] ADDR_RESULT = 2'd3;

  typedef struct packed {
    logic valid;
    logic owner;
  } rd_tag_t;

endpackage

// File: rtl/rd_return_pipe.sv
// Tracks accepted reads for READ_LAT cycles and steers the returning memory word
// to the requester that issued the read; rdata holds until that owner's next return.
module rd_return_pipe
  import matrix_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = 200,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              clk_button,
  input  logic              rst,
  input  logic              push_valid,
  input  logic              push_owner,
  input  logic [DATA_W-1:0] mem_q,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  output logic              cu_rvalid,
  output logic [DATA_W-1:0] cu_rdata
);

  rd_tag_t [READ_LAT-1:0] pipe_q;
  rd_tag_t                push_tag;
  rd_tag_t                head;
  logic [DATA_W-1:0]      host_rdata_q;
  logic [DATA_W-1:0]      cu_rdata_q;

  assign push_tag.valid = push_valid;
  assign push_tag.owner = push_owner;
  assign head           = pipe_q[READ_LAT-1];

  always_ff @(posedge clk_button or posedge rst) begin
    if (rst) begin
      pipe_q <= '0;
    end else begin
      pipe_q[0] <= push_tag;
      for (int unsigned i = 1; i < READ_LAT; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign host_rvalid = head.valid && (head.owner == OWN_HOST);
  assign cu_rvalid   = head.valid && (head.owner == OWN_CU);

  always_ff @(posedge clk_button or posedge rst) begin
    if (rst) begin
      host_rdata_q <= '0;
      cu_rdata_q   <= '0;
    end else begin
      if (host_rvalid) host_rdata_q <= mem_q;
      if (cu_rvalid)   cu_rdata_q   <= mem_q;
    end
  end

  // Return-cycle data comes straight from the macro; the register only holds it afterwards.
  assign host_rdata = host_rvalid ? mem_q : host_rdata_q;
  assign cu_rdata   = cu_rvalid   ? mem_q : cu_rdata_q;

endmodule

// File: rtl/matrix_mem_arbiter.sv
// Round-robin arbiter sharing the single-port matrix memory between the host bridge
// and the coprocessor control unit, with a CU lock that reserves the port.
module matrix_mem_arbiter
  import matrix_mem_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W   = 200,
  parameter int unsigned ADDR_W   = 2,
  parameter int unsigned READ_LAT = 1,
  parameter int unsigned WAIT_W   = 8
) (
  input  logic              clk_button,
  input  logic              rst,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] host_rdata,
  input  logic              cu_req,
  input  logic              cu_we,
  input  logic [ADDR_W-1:0] cu_addr,
  input  logic [DATA_W-1:0] cu_wdata,
  output logic              cu_gnt,
  output logic              cu_rvalid,
  output logic [DATA_W-1:0] cu_rdata,
  input  logic              cu_lock,
  output logic              locked,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q,
  output logic [WAIT_W-1:0] host_wait_cnt
);

  logic              state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              host_win, cu_win;
  logic              push_valid;

  always_comb begin
    host_win = 1'b0;
    cu_win   = 1'b0;
    if (state_q == ST_LOCKED) begin
      cu_win = cu_req;
    end else if (host_req && cu_req) begin
      host_win = (last_grant_q == OWN_CU);
      cu_win   = ~host_win;
    end else begin
      host_win = host_req;
      cu_win   = cu_req;
    end
  end

  assign host_gnt = host_win;
  assign cu_gnt   = cu_win;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    if (host_win) begin
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
      mem_wren  = host_we;
    end else if (cu_win) begin
      mem_addr  = cu_addr;
      mem_wdata = cu_wdata;
      mem_wren  = cu_we;
    end
  end

  always_comb begin
    state_d      = cu_lock ? ST_LOCKED : ST_OPEN;
    last_grant_d = last_grant_q;
    if (host_win)    last_grant_d = OWN_HOST;
    else if (cu_win) last_grant_d = OWN_CU;
    // Leaving the lock hands the next contention to the host.
    if (state_q == ST_LOCKED && !cu_lock) last_grant_d = OWN_CU;
    wait_d = wait_q;
    if (host_req && !host_win && (wait_q != '1)) wait_d = wait_q + 1'b1;
  end

  always_ff @(posedge clk_button or posedge rst) begin
    if (rst) begin
      state_q      <= ST_OPEN;
      last_grant_q <= OWN_HOST;
      wait_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      wait_q       <= wait_d;
    end
  end

  assign locked        = (state_q == ST_LOCKED);
  assign host_wait_cnt = wait_q;
  assign push_valid    = (host_win && !host_we) || (cu_win && !cu_we);

  rd_return_pipe #(
    .DATA_W   (DATA_W),
    .READ_LAT (READ_LAT)
  ) u_rd_return_pipe (
    .clk_button  (clk_button),
    .rst         (rst),
    .push_valid  (push_valid),
    .push_owner  (cu_win),
    .mem_q       (mem_q),
    .host_rvalid (host_rvalid),
    .host_rdata  (host_rdata),
    .cu_rvalid   (cu_rvalid),
    .cu_rdata    (cu_rdata)
  );

endmodule

// File: tb/tb_matrix_mem_arbiter.sv
// Bench for matrix_mem_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a transaction-level model of arbitration and read returns.
module tb_matrix_mem_arbiter;

  localparam int DATA_W   = 200;
  localparam int ADDR_W   = 2;
  localparam int READ_LAT = 2;
  localparam int WAIT_W   = 8;
  localparam int WAIT_MAX = (1 << WAIT_W) - 1;

  logic              clk_button = 1'b0;
  logic              rst = 1'b1;
  logic              host_req = 1'b0, host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_gnt, host_rvalid;
  logic [DATA_W-1:0] host_rdata;
  logic              cu_req = 1'b0, cu_we = 1'b0, cu_lock = 1'b0;
  logic [ADDR_W-1:0] cu_addr = '0;
  logic [DATA_W-1:0] cu_wdata = '0;
  logic              cu_gnt, cu_rvalid, locked, mem_wren;
  logic [DATA_W-1:0] cu_rdata, mem_wdata, mem_q;
  logic [ADDR_W-1:0] mem_addr;
  logic [WAIT_W-1:0] host_wait_cnt;

  always #5 clk_button = ~clk_button;

  matrix_mem_arbiter #(
    .DATA_W   (DATA_W),
    .ADDR_W   (ADDR_W),
    .READ_LAT (READ_LAT),
    .WAIT_W   (WAIT_W)
  ) dut (
    .clk_button    (clk_button),
    .rst           (rst),
    .host_req      (host_req),
    .host_we       (host_we),
    .host_addr     (host_addr),
    .host_wdata    (host_wdata),
    .host_gnt      (host_gnt),
    .host_rvalid   (host_rvalid),
    .host_rdata    (host_rdata),
    .cu_req        (cu_req),
    .cu_we         (cu_we),
    .cu_addr       (cu_addr),
    .cu_wdata      (cu_wdata),
    .cu_gnt        (cu_gnt),
    .cu_rvalid     (cu_rvalid),
    .cu_rdata      (cu_rdata),
    .cu_lock       (cu_lock),
    .locked        (locked),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wren      (mem_wren),
    .mem_q         (mem_q),
    .host_wait_cnt (host_wait_cnt)
  );

  // Memory macro: write-first across cycles, read data appears READ_LAT cycles later.
  logic [DATA_W-1:0] mem_arr [4];
  logic [DATA_W-1:0] dq [READ_LAT];
  initial begin
    for (int i = 0; i < 4; i++) mem_arr[i] = '0;
    for (int i = 0; i < READ_LAT; i++) dq[i] = '0;
  end
  always @(posedge clk_button) begin
    dq[0] <= mem_arr[mem_addr];
    for (int i = 1; i < READ_LAT; i++) dq[i] <= dq[i-1];
    if (mem_wren) mem_arr[mem_addr] <= mem_wdata;
  end
  assign mem_q = dq[READ_LAT-1];

  // Reference model state
  typedef struct {
    int                due;
    bit                to_cu;
    logic [DATA_W-1:0] data;
  } ret_t;
  ret_t              ret_q[$];
  bit                m_locked;
  bit                m_last_cu;
  int                m_wait;
  logic [DATA_W-1:0] m_mem [4];
  logic [DATA_W-1:0] m_hrdata, m_crdata;
  int                cyc;
  bit                last_hw, last_cw;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check(input string tag, input logic [DATA_W-1:0] got,
                       input logic [DATA_W-1:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s at cycle %0d: got %0h want %0h", tag, cyc, got, want);
    end
  endtask

  function automatic logic [DATA_W-1:0] rand_word();
    logic [DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < 7; i++) w = {w[DATA_W-33:0], $urandom()};
    return w;
  endfunction

  // One clock cycle: predict, compare, then advance the model at the edge.
  task automatic step();
    bit                hw, cw, rh, rc, wr;
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    #1;
    if (m_locked) begin
      hw = 1'b0;
      cw = cu_req;
    end else if (host_req && cu_req) begin
      hw = m_last_cu;
      cw = !m_last_cu;
    end else begin
      hw = host_req;
      cw = cu_req;
    end
    ea = '0; ed = '0; wr = 1'b0;
    if (hw) begin
      ea = host_addr; ed = host_wdata; wr = host_we;
    end else if (cw) begin
      ea = cu_addr; ed = cu_wdata; wr = cu_we;
    end
    rh = 1'b0; rc = 1'b0;
    if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
      if (ret_q[0].to_cu) begin
        rc = 1'b1; m_crdata = ret_q[0].data;
      end else begin
        rh = 1'b1; m_hrdata = ret_q[0].data;
      end
      void'(ret_q.pop_front());
    end
    check("host_gnt", host_gnt, hw);
    check("cu_gnt", cu_gnt, cw);
    check("mem_addr", mem_addr, ea);
    check("mem_wren", mem_wren, wr);
    check("mem_wdata", mem_wdata, ed);
    check("locked", locked, m_locked);
    check("host_wait_cnt", host_wait_cnt, m_wait);
    check("host_rvalid", host_rvalid, rh);
    check("host_rdata", host_rdata, m_hrdata);
    check("cu_rvalid", cu_rvalid, rc);
    check("cu_rdata", cu_rdata, m_crdata);
    last_hw = hw;
    last_cw = cw;
    @(posedge clk_button);
    if (hw || cw) begin
      if (wr) m_mem[ea] = ed;
      else ret_q.push_back('{due: cyc + READ_LAT, to_cu: cw, data: m_mem[ea]});
    end
    if (hw) m_last_cu = 1'b0;
    else if (cw) m_last_cu = 1'b1;
    if (m_locked && !cu_lock) m_last_cu = 1'b1;
    if (host_req && !hw && m_wait < WAIT_MAX) m_wait++;
    m_locked = cu_lock;
    cyc++;
    @(negedge clk_button);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    host_req = 1'b0; cu_req = 1'b0; cu_lock = 1'b0;
    #2;
    check("rst_host_gnt", host_gnt, 0);
    check("rst_cu_gnt", cu_gnt, 0);
    check("rst_mem_wren", mem_wren, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_host_rvalid", host_rvalid, 0);
    check("rst_cu_rvalid", cu_rvalid, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_cu_rdata", cu_rdata, 0);
    check("rst_locked", locked, 0);
    check("rst_wait", host_wait_cnt, 0);
    m_locked = 1'b0; m_last_cu = 1'b0; m_wait = 0;
    m_hrdata = '0; m_crdata = '0;
    ret_q.delete();
    @(posedge clk_button);
    @(negedge clk_button);
    rst = 1'b0;
  endtask

  task automatic host_set(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    host_req = 1'b1; host_we = we; host_addr = a; host_wdata = d;
  endtask

  task automatic cu_set(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    cu_req = 1'b1; cu_we = we; cu_addr = a; cu_wdata = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] pat, w0, w3;
    pat = 200'h0102030405060708090a0b0c0d0e0f10111213141516171819;
    w0  = rand_word();
    w3  = rand_word();
    for (int i = 0; i < 4; i++) m_mem[i] = '0;
    cyc = 0;
    @(negedge clk_button);
    do_reset();

    // Host write then read of matrix A.
    host_set(1'b1, 2'd1, pat);
    step();
    check("wr_gnt", last_hw, 1);
    host_set(1'b0, 2'd1, '0);
    step();
    check("rd_gnt", last_hw, 1);
    host_req = 1'b0;
    repeat (READ_LAT - 1) step();
    #1;
    check("rd_rvalid", host_rvalid, 1);
    check("rd_rdata", host_rdata, pat);
    check("rd_cu_quiet", cu_rvalid, 0);

    // CU reads word 0, host reads word 3 on the next cycle.
    host_set(1'b1, 2'd0, w0);
    step();
    host_set(1'b1, 2'd3, w3);
    step();
    host_req = 1'b0;
    cu_set(1'b0, 2'd0, '0);
    step();
    cu_req = 1'b0;
    host_set(1'b0, 2'd3, '0);
    step();
    host_req = 1'b0;
    #1;
    check("ord_cu_rvalid", cu_rvalid, 1);
    check("ord_cu_rdata", cu_rdata, w0);
    check("ord_host_quiet", host_rvalid, 0);
    step();
    #1;
    check("ord_host_rvalid", host_rvalid, 1);
    check("ord_host_rdata", host_rdata, w3);
    step();

    // Contention alternates starting with the CU.
    do_reset();
    host_set(1'b1, 2'd2, rand_word());
    cu_set(1'b1, 2'd2, rand_word());
    for (int i = 0; i < 4; i++) begin
      step();
      check("alt_cu_gnt", last_cw, (i % 2) == 0);
      check("alt_host_gnt", last_hw, (i % 2) == 1);
    end
    check("alt_wait", host_wait_cnt, 2);
    host_req = 1'b0; cu_req = 1'b0;
    step();

    // Lock holds the host off; host wins first contention after unlock.
    do_reset();
    cu_lock = 1'b1;
    step();
    host_set(1'b0, 2'd2, '0);
    for (int i = 0; i < 10; i++) begin
      step();
      check("lock_host_gnt", last_hw, 0);
      check("lock_locked", locked, 1);
    end
    check("lock_wait", host_wait_cnt, 10);
    cu_lock = 1'b0;
    step();
    cu_set(1'b0, 2'd1, '0);
    step();
    check("unlock_host_first", last_hw, 1);
    check("unlock_cu_waits", last_cw, 0);
    host_req = 1'b0;
    step();
    cu_req = 1'b0;
    repeat (READ_LAT + 1) step();

    // Wait counter saturation.
    cu_lock = 1'b1;
    step();
    host_set(1'b1, 2'd0, rand_word());
    repeat (300) step();
    check("wait_sat", host_wait_cnt, WAIT_MAX);
    host_req = 1'b0; cu_lock = 1'b0;
    step();

    // Reset with a read in flight drops it.
    host_set(1'b0, 2'd1, '0);
    step();
    host_req = 1'b0;
    do_reset();
    repeat (READ_LAT + 2) step();
    check("rst_drop_locked", locked, 0);

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      if (!host_req && $urandom_range(0, 2) == 0)
        host_set(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_word());
      if (!cu_req && $urandom_range(0, 2) == 0)
        cu_set(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_word());
      if ($urandom_range(0, 15) == 0) cu_lock = ~cu_lock;
      step();
      if (last_hw) begin
        host_req = 1'b0;
        if ($urandom_range(0, 1) == 1)
          host_set(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_word());
      end
      if (last_cw) begin
        cu_req = 1'b0;
        if ($urandom_range(0, 1) == 1)
          cu_set(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), rand_word());
      end
    end
    host_req = 1'b0; cu_req = 1'b0; cu_lock = 1'b0;
    repeat (READ_LAT + 2) step();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
